// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - frame-paced ramp sequencer driving the six-channel servo PWM bank
module servo_motion_sequencer #(
  parameter int unsigned N_CH        = 6,
  parameter int unsigned T_PERIOD    = 2000000,
  parameter int unsigned D_MIN       = 50000,
  parameter int unsigned D_MAX       = 250000,
  parameter int unsigned D_INIT      = 150000,
  parameter int unsigned STEP        = 1000,
  parameter int unsigned HOLD_FRAMES = 10
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 run,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_ch,
  input  logic [31:0]          cmd_pos,
  output logic [32*N_CH-1:0]   d_bus,
  output logic [31:0]          t_out,
  output logic [N_CH-1:0]      pwm_en,
  output logic                 frame_tick,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     cur_q [N_CH];
  logic [31:0]     cur_d [N_CH];
  logic [31:0]     tgt_q [N_CH];
  logic [31:0]     tgt_d [N_CH];
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     hold_q, hold_d;
  logic            tick_q, tick_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [N_CH-1:0] pwm_q, pwm_d;
  logic [31:0]     pos_clamped;
  logic            fire;
  logic            mism;

  always_comb begin
    fire        = cmd_valid && ready_q;
    pos_clamped = (cmd_pos < D_MIN) ? D_MIN : ((cmd_pos > D_MAX) ? D_MAX : cmd_pos);
    ready_d     = 1'b1;
    pwm_d       = {N_CH{run}};
    err_d       = fire && (int'(cmd_ch) >= int'(N_CH));
    cnt_d       = run ? ((cnt_q == T_PERIOD - 1) ? 32'd0 : cnt_q + 32'd1) : 32'd0;
    tick_d      = run && (cnt_d == T_PERIOD - 1);
    mism        = 1'b0;
    // Steps read tgt_q, so a command landing on a tick only affects the following frame.
    for (int i = 0; i < int'(N_CH); i++) begin
      cur_d[i] = cur_q[i];
      tgt_d[i] = tgt_q[i];
      if (tick_q) begin
        if (cur_q[i] < tgt_q[i])
          cur_d[i] = (tgt_q[i] - cur_q[i] > STEP) ? cur_q[i] + STEP : tgt_q[i];
        else if (cur_q[i] > tgt_q[i])
          cur_d[i] = (cur_q[i] - tgt_q[i] > STEP) ? cur_q[i] - STEP : tgt_q[i];
      end
      if (fire && int'(cmd_ch) == i)
        tgt_d[i] = pos_clamped;
      if (cur_q[i] != tgt_q[i])
        mism = 1'b1;
    end
    state_d = state_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (mism) state_d = MOVE;
      MOVE: if (!mism) begin
        state_d = HOLD;
        hold_d  = 32'd0;
      end
      HOLD: begin
        if (mism) begin
          state_d = MOVE;
        end else if (tick_q) begin
          hold_d = hold_q + 32'd1;
          if (hold_d == HOLD_FRAMES) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cur_q[i] <= D_INIT;
        tgt_q[i] <= D_INIT;
      end
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      hold_q  <= 32'd0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pwm_q   <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cur_q[i] <= cur_d[i];
        tgt_q[i] <= tgt_d[i];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pwm_q   <= pwm_d;
    end
  end

  always_comb begin
    d_bus = '0;
    for (int i = 0; i < int'(N_CH); i++)
      d_bus[32*i +: 32] = cur_q[i];
  end

  assign t_out      = 32'(T_PERIOD);
  assign cmd_ready  = ready_q;
  assign pwm_en     = pwm_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - directed bench with a per-cycle reference model of the sequencer
module tb_servo_motion_sequencer;
  localparam int N     = 6;
  localparam int T     = 100;
  localparam int DMIN  = 50000;
  localparam int DMAX  = 250000;
  localparam int DINIT = 150000;
  localparam int STEP  = 1000;
  localparam int HF    = 2;

  logic            clk = 1'b0;
  logic            res, run, cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_ch;
  logic [31:0]     cmd_pos;
  logic [32*N-1:0] d_bus;
  logic [31:0]     t_out;
  logic [N-1:0]    pwm_en;
  logic            frame_tick, busy, done, cmd_err;

  servo_motion_sequencer #(
    .N_CH(N), .T_PERIOD(T), .D_MIN(DMIN), .D_MAX(DMAX), .D_INIT(DINIT),
    .STEP(STEP), .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk), .res(res), .run(run), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .d_bus(d_bus), .t_out(t_out), .pwm_en(pwm_en),
    .frame_tick(frame_tick), .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int chv(input int i);
    return int'(d_bus[32*i +: 32]);
  endfunction

  // Reference model: state after each clock edge, written in plain integer arithmetic.
  int m_cur [N];
  int m_tgt [N];
  int m_cnt, m_hold, m_mode;
  bit m_tick, m_ready, m_err, m_done, m_pwm, m_valid = 0;
  bit o_tick, o_ready, o_mism;
  int diff;
  longint req;

  always @(posedge clk) begin
    cyc++;
    if (res) begin
      for (int i = 0; i < N; i++) begin m_cur[i] = DINIT; m_tgt[i] = DINIT; end
      m_cnt = 0; m_hold = 0; m_mode = 0;
      m_tick = 0; m_ready = 0; m_err = 0; m_done = 0; m_pwm = 0;
      m_valid = 1;
    end else if (m_valid) begin
      o_tick  = m_tick;
      o_ready = m_ready;
      o_mism  = 0;
      for (int i = 0; i < N; i++) if (m_cur[i] != m_tgt[i]) o_mism = 1;
      if (o_tick)
        for (int i = 0; i < N; i++) begin
          diff = m_tgt[i] - m_cur[i];
          if (diff > STEP) diff = STEP;
          if (diff < -STEP) diff = -STEP;
          m_cur[i] = m_cur[i] + diff;
        end
      m_err = 0;
      if (cmd_valid && o_ready) begin
        req = longint'(cmd_pos);
        if (req < DMIN) req = DMIN;
        if (req > DMAX) req = DMAX;
        if (int'(cmd_ch) < N) m_tgt[cmd_ch] = int'(req);
        else m_err = 1;
      end
      m_done = 0;
      if (m_mode == 0) begin
        if (o_mism) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!o_mism) begin m_mode = 2; m_hold = 0; end
      end else begin
        if (o_mism) m_mode = 1;
        else if (o_tick) begin
          m_hold++;
          if (m_hold == HF) begin m_mode = 0; m_done = 1; end
        end
      end
      m_cnt   = run ? (m_cnt + 1) % T : 0;
      m_tick  = run && (m_cnt == T - 1);
      m_ready = 1;
      m_pwm   = run;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) chk($sformatf("model_d_bus_ch%0d", i), chv(i), m_cur[i]);
      chk("model_busy", busy, m_mode != 0);
      chk("model_done", done, m_done);
      chk("model_cmd_ready", cmd_ready, m_ready);
      chk("model_frame_tick", frame_tick, m_tick);
      chk("model_pwm_en", pwm_en, m_pwm ? {N{1'b1}} : '0);
      chk("model_cmd_err", cmd_err, m_err);
      chk("model_t_out", t_out, T);
    end
  end

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 250);
    chk({"tick_seen_", tag}, frame_tick, 1);
  endtask

  task automatic send(input int ch, input int pos);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_ch = ch[2:0]; cmd_pos = pos;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  int t1, cnt_ev;
  int ramp0 [4] = '{151000, 152000, 153000, 153500};

  initial begin
    res = 1; run = 1; cmd_valid = 0; cmd_ch = 0; cmd_pos = 0;
    repeat (3) @(posedge clk);
    #1 res = 0;

    // 1: reset state and frame cadence
    @(negedge clk);
    chk("t1_ready_low_first_cycle", cmd_ready, 0);
    chk("t1_busy", busy, 0);
    chk("t1_pwm_en_reset", pwm_en, 0);
    for (int i = 0; i < N; i++) chk($sformatf("t1_ch%0d", i), chv(i), 150000);
    @(negedge clk);
    chk("t1_ready_high", cmd_ready, 1);
    chk("t1_pwm_en_run", pwm_en, 6'h3f);
    wait_tick("t1a");
    t1 = cyc;
    wait_tick("t1b");
    chk("t1_tick_period", cyc - t1, 100);

    // 2: ramp ch0 to 153500, then settle
    send(0, 153500);
    @(negedge clk);
    @(negedge clk);
    chk("t2_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      wait_tick("t2");
      @(negedge clk);
      chk($sformatf("t2_ch0_step%0d", k), chv(0), ramp0[k]);
      chk("t2_ch1_still", chv(1), 150000);
    end
    wait_tick("t2h1");
    wait_tick("t2h2");
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_idle", busy, 0);

    // 3: clamping and illegal channel
    send(2, 300000);
    send(3, 10);
    send(7, 160000);
    @(negedge clk);
    chk("t3_cmd_err", cmd_err, 1);
    chk("t3_ch0_unchanged", chv(0), 153500);
    chk("t3_ch4_unchanged", chv(4), 150000);
    for (int k = 0; k < 100; k++) wait_tick("t3");
    @(negedge clk);
    chk("t3_ch2_max", chv(2), 250000);
    chk("t3_ch3_min", chv(3), 50000);
    wait_tick("t3x");
    @(negedge clk);
    chk("t3_ch2_stays", chv(2), 250000);
    chk("t3_ch3_stays", chv(3), 50000);

    // 4: command coinciding with a tick
    wait_tick("t4a");
    cmd_valid = 1; cmd_ch = 3'd1; cmd_pos = 160000;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("t4_no_step_on_tick", chv(1), 150000);
    wait_tick("t4b");
    @(negedge clk);
    chk("t4_step_next", chv(1), 151000);

    // 5: freeze with run=0
    @(posedge clk); #1 run = 0;
    cnt_ev = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (frame_tick) cnt_ev++;
    end
    chk("t5_no_ticks", cnt_ev, 0);
    chk("t5_frozen", chv(1), 151000);
    chk("t5_pwm_off", pwm_en, 0);
    @(posedge clk); #1 run = 1;
    wait_tick("t5");
    @(negedge clk);
    chk("t5_resume", chv(1), 152000);

    // 6: reset during MOVE, then during HOLD
    chk("t6_busy_move", busy, 1);
    @(posedge clk); #1 res = 1;
    @(posedge clk); #1 res = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("t6_move_ch%0d", i), chv(i), 150000);
    chk("t6_idle_after_move_reset", busy, 0);
    chk("t6_ready_low", cmd_ready, 0);
    send(0, 151000);
    wait_tick("t6");
    @(negedge clk);
    chk("t6_ch0_reached", chv(0), 151000);
    repeat (3) @(negedge clk);
    chk("t6_busy_hold", busy, 1);
    @(posedge clk); #1 res = 1;
    @(posedge clk); #1 res = 0;
    cnt_ev = 0;
    @(negedge clk);
    chk("t6_hold_ch0", chv(0), 150000);
    chk("t6_idle_after_hold_reset", busy, 0);
    for (int k = 0; k < 300; k++) begin
      if (done) cnt_ev++;
      @(negedge clk);
    end
    chk("t6_no_done", cnt_ev, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
